// File: rtl/fifo_mem_ctrl_pkg.sv
// Shared widths and pointer helpers for the FIFO controller and its memory.
package fifo_mem_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PTR_W  = ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Occupancy between two wrap pointers; modulo arithmetic handles the wrap bit.
    function automatic ptr_t ptr_diff(input ptr_t wr, input ptr_t rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap counter used for the FIFO read and write pointers.
// The extra MSB distinguishes a full FIFO from an empty one.
module fifo_ptr #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o,
    output logic [W-1:0] nxt_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer value, exposed so the flags can be registered from it.
    always_comb begin
        ptr_d = ptr_q + {{(W-1){1'b0}}, inc_i};
    end

    // Pointer register; wraps naturally at 2**W.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
    assign nxt_o = ptr_d;

endmodule

// File: rtl/memory.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are never cleared.
module memory
    import fifo_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = fifo_mem_ctrl_pkg::DATA_W,
    parameter int ADDR_W = fifo_mem_ctrl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] read_data
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (write_enable) mem_q[write_address] <= write_data;
    end

    // Registered read port; data appears one cycle after read_enable.
    always_ff @(posedge clk) begin
        if (read_enable) read_data <= mem_q[read_address];
    end

endmodule

// File: rtl/fifo_mem_ctrl.sv
// FIFO controller driving an external two-port memory.
// Tracks wrap pointers, produces registered count/empty/full flags,
// and pulses overflow/underflow when a request has to be dropped.
module fifo_mem_ctrl
    import fifo_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = fifo_mem_ctrl_pkg::DATA_W,
    parameter int ADDR_W = fifo_mem_ctrl_pkg::ADDR_W,
    parameter int DEPTH  = fifo_mem_ctrl_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              overflow,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic              underflow,
    output logic [ADDR_W:0]   count,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              read_enable,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] read_data
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wr_ptr, wr_nxt;
    logic [PW-1:0] rd_ptr, rd_nxt;
    logic [PW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic          pop_valid_q, overflow_q, underflow_q;
    logic          push_ok, pop_ok;

    // Accept decisions use the flags held at the start of the cycle;
    // requests are ignored while reset is asserted.
    always_comb begin
        push_ok = push & ~full_q  & ~rst;
        pop_ok  = pop  & ~empty_q & ~rst;
        count_d = wr_nxt - rd_nxt;
    end

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push_ok),
        .ptr_o (wr_ptr),
        .nxt_o (wr_nxt)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop_ok),
        .ptr_o (rd_ptr),
        .nxt_o (rd_nxt)
    );

    // Flags and pulses, all registered from the next pointer values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == PW'(DEPTH));
            pop_valid_q <= pop_ok;
            overflow_q  <= push & full_q;
            underflow_q <= pop & empty_q;
        end
    end

    // Memory drive follows the accept signals directly; the two addresses
    // never collide because pop needs count>0 and push needs count<DEPTH.
    assign write_enable  = push_ok;
    assign write_address = wr_ptr[ADDR_W-1:0];
    assign write_data    = push_data;
    assign read_enable   = pop_ok;
    assign read_address  = rd_ptr[ADDR_W-1:0];

    // A pop accepted just before reset is discarded: valid is masked by rst.
    assign pop_valid = pop_valid_q & ~rst;
    assign pop_data  = read_data;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl + memory against a queue-based FIFO model.
module tb_fifo_mem_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DP = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic          full, overflow, pop_valid, empty, underflow;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;
    logic          write_enable, read_enable;
    logic [AW-1:0] write_address, read_address;
    logic [DW-1:0] write_data, read_data;

    always #5 clk = ~clk;

    fifo_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_data     (push_data),
        .full          (full),
        .overflow      (overflow),
        .pop           (pop),
        .pop_data      (pop_data),
        .pop_valid     (pop_valid),
        .empty         (empty),
        .underflow     (underflow),
        .count         (count),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .read_data     (read_data)
    );

    memory #(.DATA_W(DW), .ADDR_W(AW)) u_mem (
        .clk           (clk),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .read_data     (read_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    int unsigned   wcnt = 0;
    int unsigned   rcnt = 0;
    bit            pv_m = 0, ovf_m = 0, udf_m = 0;
    logic [DW-1:0] exp_pd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check registered state, drive inputs, check combinational
    // outputs, let the edge pass, then advance the model.
    task automatic cyc(input bit r, input bit p, input bit o, input logic [DW-1:0] d);
        bit push_ok, pop_ok;
        int sz;
        @(negedge clk);
        sz = q.size();
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DP));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("underflow", 32'(underflow), 32'(udf_m));
        rst = r; push = p; pop = o; push_data = d;
        push_ok = !r && p && (sz < DP);
        pop_ok  = !r && o && (sz > 0);
        #1;
        chk("write_enable", 32'(write_enable), 32'(push_ok));
        chk("read_enable", 32'(read_enable), 32'(pop_ok));
        if (push_ok) begin
            chk("write_address", 32'(write_address), wcnt % DP);
            chk("write_data", 32'(write_data), 32'(d));
        end
        if (pop_ok) chk("read_address", 32'(read_address), rcnt % DP);
        chk("pop_valid", 32'(pop_valid), 32'(pv_m && !r));
        if (pv_m && !r) chk("pop_data", 32'(pop_data), 32'(exp_pd));
        @(posedge clk);
        if (r) begin
            q.delete();
            wcnt = 0; rcnt = 0;
            pv_m = 0; ovf_m = 0; udf_m = 0;
        end else begin
            if (pop_ok) begin
                exp_pd = q.pop_front();
                rcnt++;
            end
            if (push_ok) begin
                q.push_back(d);
                wcnt++;
            end
            pv_m  = pop_ok;
            ovf_m = p && (sz == DP);
            udf_m = o && (sz == 0);
        end
        #1;
    endtask

    initial begin
        // 1. Reset
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // 2. Write then read
        cyc(1'b0, 1'b1, 1'b0, 8'h3B);
        cyc(1'b0, 1'b1, 1'b0, 8'h3D);
        chk("wr2_count", 32'(count), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("rd1_valid", 32'(pop_valid), 32'd1);
        chk("rd1_data", 32'(pop_data), 32'h3B);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("rd2_valid", 32'(pop_valid), 32'd1);
        chk("rd2_data", 32'(pop_data), 32'h3D);
        chk("rd2_count", 32'(count), 32'd0);
        chk("rd2_empty", 32'(empty), 32'd1);

        // 3. Fill
        for (int i = 0; i < DP; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd256);
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd256);

        // 4. Full push+pop
        cyc(1'b0, 1'b1, 1'b1, 8'h55);
        chk("fpp_data", 32'(pop_data), 32'h00);
        chk("fpp_count", 32'(count), 32'd255);
        chk("fpp_ovf", 32'(overflow), 32'd1);
        chk("fpp_full", 32'(full), 32'd0);

        // 5. Wrap-around with random interleaved traffic
        for (int i = 0; i < 300; i++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'($urandom));
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
        end
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("drain_empty", 32'(empty), 32'd1);

        // 6. Empty pop, then mid-operation reset
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_pulse", 32'(underflow), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'hC7);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("mrst_valid", 32'(pop_valid), 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #2000000;
        $display("FAIL timeout: run did not complete, expected finish before 2000000");
        $fatal(1);
    end

endmodule
